// File: rtl/dmem_wb_master_pkg.sv
// Shared constants and state encoding for the data-memory Wishbone master.
package dmem_wb_master_pkg;

   // Physical address width produced by the data MMU.
   localparam int PHYS_ADDR_W     = 24;
   // CPU register / data width.
   localparam int RW              = 16;
   // Default watchdog limit in cycles (fits the 8-bit counter).
   localparam int TIMEOUT_CYC_DEF = 255;

   // Bus-master state; also visible on the debug port.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

endpackage

// File: rtl/dmem_wb_master.sv
// Data-memory Wishbone master: turns one latched CPU load/store into one
// pipelined single-beat Wishbone cycle and reports ack/err/read data back.
// Optional watchdog: define DMEM_WB_TIMEOUT_EN to abort with o_err after
// TIMEOUT_CYC cycles in REQ/WAIT without a slave response.
//
// Handshake: a request is taken only when i_req=1 in IDLE (o_busy=0); the
// strobe is accepted on any cycle with o_wb_stb=1 and i_wb_stall=0; the
// slave response (i_wb_ack / i_wb_err) is honoured only from that cycle
// until completion, and err takes priority over ack.
module dmem_wb_master
   import dmem_wb_master_pkg::*;
#(
   parameter int ADDR_W      = PHYS_ADDR_W,
   parameter int DATA_W      = RW,
   parameter int SEL_W       = DATA_W / 8,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_data,
   input  logic [SEL_W-1:0]  i_sel,
   output logic              o_busy,
   output logic              o_ack,
   output logic              o_err,
   output logic [DATA_W-1:0] o_data,
   output logic              o_wb_cyc,
   output logic              o_wb_stb,
   output logic              o_wb_we,
   output logic [ADDR_W-1:0] o_wb_adr,
   output logic [DATA_W-1:0] o_wb_dat,
   output logic [SEL_W-1:0]  o_wb_sel,
   input  logic [DATA_W-1:0] i_wb_dat,
   input  logic              i_wb_ack,
   input  logic              i_wb_err,
   input  logic              i_wb_stall,
   output state_t            o_dbg_state
);

   // The watchdog counter is 8 bits wide, so the limit must fit in it.
   if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be in 1..255 for the 8-bit watchdog");
   end

   state_t              state_q, state_d;
   logic                cyc_d, stb_d, we_d, ack_d, err_d, busy_d;
   logic [ADDR_W-1:0]   adr_d;
   logic [DATA_W-1:0]   wdat_d, rdat_d;
   logic [SEL_W-1:0]    sel_d;
   logic                resp_ok;
   logic                timeout;

   assign o_dbg_state = state_q;

`ifdef DMEM_WB_TIMEOUT_EN
   logic [7:0] tmo_cnt_q;

   // Watchdog: zero while idle, so it reads 0 in the first REQ cycle.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst)
         tmo_cnt_q <= '0;
      else if (state_q == S_IDLE)
         tmo_cnt_q <= '0;
      else
         tmo_cnt_q <= tmo_cnt_q + 8'd1;
   end

   assign timeout = (state_q != S_IDLE) && (tmo_cnt_q == 8'(TIMEOUT_CYC - 1));
`else
   assign timeout = 1'b0;
`endif

   // State and all outputs are registered; reset drops the bus at once.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q  <= S_IDLE;
         o_wb_cyc <= 1'b0;
         o_wb_stb <= 1'b0;
         o_wb_we  <= 1'b0;
         o_wb_adr <= '0;
         o_wb_dat <= '0;
         o_wb_sel <= '0;
         o_data   <= '0;
         o_ack    <= 1'b0;
         o_err    <= 1'b0;
         o_busy   <= 1'b0;
      end else begin
         state_q  <= state_d;
         o_wb_cyc <= cyc_d;
         o_wb_stb <= stb_d;
         o_wb_we  <= we_d;
         o_wb_adr <= adr_d;
         o_wb_dat <= wdat_d;
         o_wb_sel <= sel_d;
         o_data   <= rdat_d;
         o_ack    <= ack_d;
         o_err    <= err_d;
         o_busy   <= busy_d;
      end
   end

   // Next-state and next-output decode; everything holds unless changed.
   always_comb begin
      state_d = state_q;
      cyc_d   = o_wb_cyc;
      stb_d   = o_wb_stb;
      we_d    = o_wb_we;
      adr_d   = o_wb_adr;
      wdat_d  = o_wb_dat;
      sel_d   = o_wb_sel;
      rdat_d  = o_data;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      // A response only counts once the strobe has been accepted.
      resp_ok = (state_q == S_WAIT) || ((state_q == S_REQ) && !i_wb_stall);

      case (state_q)
         S_IDLE: begin
            if (i_req) begin
               state_d = S_REQ;
               cyc_d   = 1'b1;
               stb_d   = 1'b1;
               we_d    = i_we;
               adr_d   = i_addr;
               wdat_d  = i_data;
               sel_d   = i_sel;
            end
         end
         S_REQ, S_WAIT: begin
            if (resp_ok && i_wb_err) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
               cyc_d   = 1'b0;
               stb_d   = 1'b0;
            end else if (resp_ok && i_wb_ack) begin
               ack_d   = 1'b1;
               if (!o_wb_we)
                  rdat_d = i_wb_dat;
               state_d = S_IDLE;
               cyc_d   = 1'b0;
               stb_d   = 1'b0;
            end else if (timeout) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
               cyc_d   = 1'b0;
               stb_d   = 1'b0;
            end else if ((state_q == S_REQ) && !i_wb_stall) begin
               stb_d   = 1'b0;
               state_d = S_WAIT;
            end
         end
         default: begin
            state_d = S_IDLE;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

endmodule

// File: tb/tb_dmem_wb_master.sv
// Self-checking bench for dmem_wb_master: directed scenarios followed by
// randomized transactions checked against a transaction-level model.
module tb_dmem_wb_master;
   import dmem_wb_master_pkg::*;

   logic        i_clk;
   logic        i_rst;
   logic        i_req;
   logic        i_we;
   logic [23:0] i_addr;
   logic [15:0] i_data;
   logic [1:0]  i_sel;
   logic        o_busy, o_ack, o_err;
   logic [15:0] o_data;
   logic        o_wb_cyc, o_wb_stb, o_wb_we;
   logic [23:0] o_wb_adr;
   logic [15:0] o_wb_dat;
   logic [1:0]  o_wb_sel;
   logic [15:0] i_wb_dat;
   logic        i_wb_ack, i_wb_err, i_wb_stall;
   state_t      dbg_state;

   int          checks   = 0;
   int          failures = 0;
   logic [15:0] model_data;

   dmem_wb_master #(
      .ADDR_W(24), .DATA_W(16), .SEL_W(2), .TIMEOUT_CYC(8)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_we(i_we),
      .i_addr(i_addr), .i_data(i_data), .i_sel(i_sel),
      .o_busy(o_busy), .o_ack(o_ack), .o_err(o_err), .o_data(o_data),
      .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
      .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat), .o_wb_sel(o_wb_sel),
      .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
      .i_wb_stall(i_wb_stall), .o_dbg_state(dbg_state)
   );

   // Clock
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "simulation time limit reached");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; drive and sample 1 time unit after the rising edge.
   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   // One transaction. stalls = stall cycles on the strobe; delay = WAIT cycles
   // with no response (0 = respond in the strobe-accept cycle);
   // kind 0 = ack, 1 = err, 2 = ack and err together.
   task automatic run_txn(input logic we, input logic [23:0] addr, input logic [15:0] wdat,
                          input logic [1:0] sel, input int stalls, input int delay,
                          input int kind, input logic [15:0] rdat);
      logic        exp_ack, exp_err;
      logic [15:0] exp_data;
      exp_ack  = (kind == 0);
      exp_err  = (kind != 0);
      exp_data = (exp_ack && !we) ? rdat : model_data;

      i_req = 1'b1; i_we = we; i_addr = addr; i_data = wdat; i_sel = sel;
      step();
      // Request was latched: scramble the CPU side to prove it.
      i_req = 1'b0; i_we = ~we; i_addr = ~addr; i_data = ~wdat; i_sel = ~sel;
      check("start_cyc", o_wb_cyc, 1);
      check("start_stb", o_wb_stb, 1);
      check("start_busy", o_busy, 1);
      check("start_we", o_wb_we, we);
      check("start_adr", o_wb_adr, addr);
      check("start_dat", o_wb_dat, wdat);
      check("start_sel", o_wb_sel, sel);

      for (int s = 0; s < stalls; s++) begin
         i_wb_stall = 1'b1;
         i_wb_ack   = 1'($urandom_range(0, 1));
         i_wb_err   = 1'($urandom_range(0, 1));
         step();
         check("stall_stb", o_wb_stb, 1);
         check("stall_adr", o_wb_adr, addr);
         check("stall_dat", o_wb_dat, wdat);
         check("stall_sel", o_wb_sel, sel);
         check("stall_resp", {o_ack, o_err}, 2'b00);
      end
      i_wb_stall = 1'b0; i_wb_ack = 1'b0; i_wb_err = 1'b0;

      for (int w = 0; w < delay; w++) begin
         step();
         check("wait_stb", o_wb_stb, 0);
         check("wait_cyc", o_wb_cyc, 1);
         check("wait_busy", o_busy, 1);
         check("wait_resp", {o_ack, o_err}, 2'b00);
      end

      i_wb_ack = (kind != 1);
      i_wb_err = (kind != 0);
      i_wb_dat = rdat;
      step();
      i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_dat = 16'($urandom);
      check("done_ack", o_ack, exp_ack);
      check("done_err", o_err, exp_err);
      check("done_cyc", o_wb_cyc, 0);
      check("done_stb", o_wb_stb, 0);
      check("done_busy", o_busy, 0);
      check("done_data", o_data, exp_data);
      model_data = exp_data;

      step();
      check("pulse_end", {o_ack, o_err}, 2'b00);
      check("data_hold", o_data, model_data);
   endtask

   initial begin
      int n_stb, n_ack, n;
      logic        r_we;
      logic [23:0] r_addr;
      logic [15:0] r_wdat, r_rdat;
      logic [1:0]  r_sel;
      int          r_kind;

      // Reset
      i_rst = 1'b0; i_req = 1'b0; i_we = 1'b0; i_addr = '0; i_data = '0; i_sel = '0;
      i_wb_dat = '0; i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_stall = 1'b0;
      model_data = '0;
      step();
      step();
      check("rst_cyc", o_wb_cyc, 0);
      check("rst_stb", o_wb_stb, 0);
      check("rst_pulses", {o_ack, o_err, o_busy}, 3'b000);
      check("rst_data", o_data, 0);
      check("rst_bus", {o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel}, 0);
      i_rst = 1'b1;
      step();

      // Load, no stall, ack in the strobe cycle.
      run_txn(1'b0, 24'h10_0040, 16'h0000, 2'b11, 0, 0, 0, 16'hBEEF);
      // Store, three stall cycles, read data must not update.
      run_txn(1'b1, 24'h01_2345, 16'hA55A, 2'b10, 3, 1, 0, 16'h1234);
      // ack and err together in WAIT: err wins.
      run_txn(1'b0, 24'h00_0100, 16'h0000, 2'b11, 0, 2, 2, 16'h7777);

      // Stray ack while idle is ignored.
      i_wb_ack = 1'b1; i_wb_dat = 16'hDEAD;
      step();
      i_wb_ack = 1'b0;
      check("idle_ack", {o_ack, o_err, o_busy}, 3'b000);
      check("idle_data", o_data, model_data);

      // Back-to-back: i_req held high across two transactions.
      i_req = 1'b1; i_we = 1'b0; i_addr = 24'h00_00A1; i_sel = 2'b11;
      step();
      check("b2b_stb1", o_wb_stb, 1);
      i_wb_ack = 1'b1; i_wb_dat = 16'h1111;
      step();
      check("b2b_ack1", o_ack, 1);
      check("b2b_data1", o_data, 16'h1111);
      check("b2b_idle", o_busy, 0);
      i_wb_ack = 1'b0; i_addr = 24'h00_00A2;
      step();
      check("b2b_stb2", o_wb_stb, 1);
      check("b2b_adr2", o_wb_adr, 24'h00_00A2);
      i_wb_ack = 1'b1; i_wb_dat = 16'h2222;
      step();
      i_req = 1'b0; i_wb_ack = 1'b0;
      check("b2b_ack2", o_ack, 1);
      check("b2b_data2", o_data, 16'h2222);
      model_data = 16'h2222;
      n_stb = 0; n_ack = 0;
      for (int c = 0; c < 6; c++) begin
         step();
         n_stb += int'(o_wb_stb);
         n_ack += int'(o_ack);
      end
      check("b2b_extra_stb", n_stb, 0);
      check("b2b_extra_ack", n_ack, 0);

      // Randomized transactions against the model.
      for (int t = 0; t < 16; t++) begin
         r_we   = 1'($urandom_range(0, 1));
         r_addr = 24'($urandom);
         r_wdat = 16'($urandom);
         r_rdat = 16'($urandom);
         r_sel  = 2'($urandom_range(0, 3));
         r_kind = $urandom_range(0, 5);
         r_kind = (r_kind < 4) ? 0 : r_kind - 3;
         run_txn(r_we, r_addr, r_wdat, r_sel, $urandom_range(0, 3), $urandom_range(0, 3),
                 r_kind, r_rdat);
      end

      // Asynchronous reset in WAIT, then a stray ack, then a fresh load.
      i_req = 1'b1; i_we = 1'b0; i_addr = 24'h00_0F00;
      step();
      i_req = 1'b0;
      step();
      check("arst_pre_cyc", o_wb_cyc, 1);
      check("arst_pre_stb", o_wb_stb, 0);
      #2;
      i_rst = 1'b0;
      #1;
      check("arst_cyc", o_wb_cyc, 0);
      check("arst_stb", o_wb_stb, 0);
      check("arst_busy", o_busy, 0);
      check("arst_data", o_data, 0);
      model_data = '0;
      @(posedge i_clk);
      #1;
      i_rst = 1'b1;
      i_wb_ack = 1'b1; i_wb_dat = 16'h5555;
      step();
      i_wb_ack = 1'b0;
      check("arst_no_ack", {o_ack, o_err}, 2'b00);
      step();
      check("arst_idle", {o_ack, o_busy, o_wb_cyc}, 3'b000);
      run_txn(1'b0, 24'h00_0F04, 16'h0000, 2'b01, 1, 1, 0, 16'hC0DE);

`ifdef DMEM_WB_TIMEOUT_EN
      // Silent slave: the watchdog aborts 8 cycles after entering REQ.
      i_req = 1'b1; i_we = 1'b0; i_addr = 24'h00_0200;
      step();
      i_req = 1'b0;
      n = 0;
      while (o_err !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      check("tmo_latency", n, 8);
      check("tmo_cyc", o_wb_cyc, 0);
      check("tmo_busy", o_busy, 0);
      check("tmo_ack", o_ack, 0);
      i_wb_ack = 1'b1; i_wb_dat = 16'h9999;
      step();
      i_wb_ack = 1'b0;
      check("tmo_late_ack", {o_ack, o_err}, 2'b00);
      check("tmo_data", o_data, model_data);
`else
      // Silent slave: without the watchdog the master keeps waiting.
      i_req = 1'b1; i_we = 1'b0; i_addr = 24'h00_0200;
      step();
      i_req = 1'b0;
      n = 0;
      for (int c = 0; c < 20; c++) begin
         step();
         n += int'(o_err);
      end
      check("nowd_err", n, 0);
      check("nowd_cyc", o_wb_cyc, 1);
      check("nowd_busy", o_busy, 1);
      i_wb_ack = 1'b1; i_wb_dat = 16'h4242;
      step();
      i_wb_ack = 1'b0;
      check("nowd_ack", o_ack, 1);
      check("nowd_data", o_data, 16'h4242);
      model_data = 16'h4242;
`endif

      step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
